// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and encodings for the decode stage
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

   localparam logic [2:0] FUNCT3_ADD = 3'b000;
   localparam logic [2:0] FUNCT3_XOR = 3'b100;
   localparam logic [2:0] FUNCT3_OR  = 3'b110;
   localparam logic [2:0] FUNCT3_AND = 3'b111;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_NOP = 3'd0,
      ALU_ADD = 3'd1,
      ALU_SUB = 3'd2,
      ALU_XOR = 3'd3,
      ALU_OR  = 3'd4,
      ALU_AND = 3'd5
   } alu_op_t;

   typedef enum logic { SRC_A_RS1 = 1'b0, SRC_A_PC  = 1'b1 } src_a_sel_t;
   typedef enum logic { SRC_B_RS2 = 1'b0, SRC_B_IMM = 1'b1 } src_b_sel_t;
   typedef enum logic { WRITE_DISABLE = 1'b0, WRITE_ENABLE = 1'b1 } reg_write_t;

   typedef struct packed {
      alu_op_t    alu_op;
      src_a_sel_t src_a_sel;
      src_b_sel_t src_b_sel;
      reg_write_t reg_write;
   } control_signals_t;

   localparam control_signals_t CTRL_NOP = '{ALU_NOP, SRC_A_RS1, SRC_B_RS2, WRITE_DISABLE};

   typedef struct packed {
      control_signals_t  ctrl;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [XLEN-1:0]   imm;
      logic              illegal;
   } decoded_t;

   localparam decoded_t DECODED_RST = '{CTRL_NOP, 5'd0, 5'd0, 5'd0, '0, 1'b0};

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface decode_stage_if #(parameter int XLEN = 32);
   import cpu_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_instr;
   logic [XLEN-1:0]     in_pc;

   logic                out_valid;
   logic                out_ready;
   control_signals_t    out_ctrl;
   logic [4:0]          out_rs1;
   logic [4:0]          out_rs2;
   logic [4:0]          out_rd;
   logic [XLEN-1:0]     out_imm;
   logic [XLEN-1:0]     out_pc;
   logic                out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_ctrl, out_rs1, out_rs2, out_rd,
             out_imm, out_pc, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_ctrl, out_rs1, out_rs2, out_rd,
             out_imm, out_pc, out_illegal
   );

endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational instruction word to decoded_t translation
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [31:0] instr_i,
   output decoded_t    dec_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   alu_op_t    op;
   logic       legal;
   logic       use_imm;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   always_comb begin
      op      = ALU_NOP;
      legal   = 1'b0;
      use_imm = 1'b0;
      if (opcode == OPCODE_OP) begin
         if (funct7 == FUNCT7_BASE) begin
            legal = 1'b1;
            case (funct3)
               FUNCT3_ADD: op = ALU_ADD;
               FUNCT3_XOR: op = ALU_XOR;
               FUNCT3_OR:  op = ALU_OR;
               FUNCT3_AND: op = ALU_AND;
               default:    legal = 1'b0;
            endcase
         end else if (funct7 == FUNCT7_SUB && funct3 == FUNCT3_ADD) begin
            legal = 1'b1;
            op    = ALU_SUB;
         end
      end else if (opcode == OPCODE_OP_IMM) begin
         // funct7 position carries immediate bits here, so it is not examined
         legal   = 1'b1;
         use_imm = 1'b1;
         case (funct3)
            FUNCT3_ADD: op = ALU_ADD;
            FUNCT3_XOR: op = ALU_XOR;
            FUNCT3_OR:  op = ALU_OR;
            FUNCT3_AND: op = ALU_AND;
            default:    legal = 1'b0;
         endcase
      end
   end

   always_comb begin
      dec_o.rs1     = instr_i[19:15];
      dec_o.rs2     = instr_i[24:20];
      dec_o.rd      = instr_i[11:7];
      dec_o.imm     = XLEN'($signed(instr_i[31:20]));
      dec_o.illegal = !legal;
      dec_o.ctrl    = CTRL_NOP;
      if (legal) begin
         dec_o.ctrl.alu_op    = op;
         dec_o.ctrl.src_a_sel = SRC_A_RS1;
         dec_o.ctrl.src_b_sel = use_imm ? SRC_B_IMM : SRC_B_RS2;
         dec_o.ctrl.reg_write = (instr_i[11:7] == 5'd0) ? WRITE_DISABLE : WRITE_ENABLE;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered ID stage: handshake, output bundle register, illegal counter
module decode_stage
   import cpu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   decode_stage_if.slave    bus,
   output logic [CNT_W-1:0] illegal_cnt
);

   decoded_t         dec;
   decoded_t         bundle_q, bundle_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   instr_decoder u_decoder (
      .instr_i (bus.in_instr),
      .dec_o   (dec)
   );

   assign bus.in_ready = !flush_i && (!valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      bundle_d = bundle_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      // flush wins over everything; in_ready is already low so accept cannot fire
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d  = 1'b1;
         bundle_d = dec;
         pc_d     = bus.in_pc;
         if (dec.illegal && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bundle_q <= DECODED_RST;
         pc_q     <= '0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         bundle_q <= bundle_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.out_valid   = valid_q;
   assign bus.out_ctrl    = bundle_q.ctrl;
   assign bus.out_rs1     = bundle_q.rs1;
   assign bus.out_rs2     = bundle_q.rs2;
   assign bus.out_rd      = bundle_q.rd;
   assign bus.out_imm     = bundle_q.imm;
   assign bus.out_pc      = pc_q;
   assign bus.out_illegal = bundle_q.illegal;
   assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
   import cpu_pkg::*;

   localparam int CNT_W = 8;

   localparam control_signals_t C_ADD_R   = '{ALU_ADD, SRC_A_RS1, SRC_B_RS2, WRITE_ENABLE};
   localparam control_signals_t C_ADD_R0  = '{ALU_ADD, SRC_A_RS1, SRC_B_RS2, WRITE_DISABLE};
   localparam control_signals_t C_SUB_R   = '{ALU_SUB, SRC_A_RS1, SRC_B_RS2, WRITE_ENABLE};
   localparam control_signals_t C_XOR_R   = '{ALU_XOR, SRC_A_RS1, SRC_B_RS2, WRITE_ENABLE};
   localparam control_signals_t C_ADD_I   = '{ALU_ADD, SRC_A_RS1, SRC_B_IMM, WRITE_ENABLE};
   localparam control_signals_t C_NOP     = '{ALU_NOP, SRC_A_RS1, SRC_B_RS2, WRITE_DISABLE};

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush_i = 1'b0;
   logic [CNT_W-1:0] illegal_cnt;
   int               total = 0;
   int               bad   = 0;

   decode_stage_if #(.XLEN(32)) bus ();

   decode_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .bus         (bus),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = v;
      bus.in_instr = instr;
      bus.in_pc    = pc;
   endtask

   task automatic test_reset();
      bus.out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      tick();
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      total++; if (illegal_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); end
      total++; if (bus.out_ctrl !== C_NOP) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", bus.out_ctrl, C_NOP); end
      total++; if ({bus.out_pc, bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_illegal} !== '0) begin
         bad++; $display("FAIL reset_fields pc=%h imm=%h ill=%b exp all zero", bus.out_pc, bus.out_imm, bus.out_illegal);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h002081B3, 32'h100);
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b exp=1", bus.in_ready); end
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", bus.out_valid); end
      total++; if (bus.out_ctrl !== C_ADD_R) begin bad++; $display("FAIL add_ctrl got=%h exp=%h", bus.out_ctrl, C_ADD_R); end
      total++; if ({bus.out_rs1, bus.out_rs2, bus.out_rd} !== {5'd1, 5'd2, 5'd3}) begin
         bad++; $display("FAIL add_regs got=%0d,%0d,%0d exp=1,2,3", bus.out_rs1, bus.out_rs2, bus.out_rd);
      end
      total++; if (bus.out_pc !== 32'h100 || bus.out_illegal !== 1'b0) begin
         bad++; $display("FAIL add_pc got=%h ill=%b exp=100 ill=0", bus.out_pc, bus.out_illegal);
      end
      drive(1'b1, 32'h00208033, 32'h104);
      tick();
      total++; if (bus.out_ctrl !== C_ADD_R0) begin bad++; $display("FAIL add_rd0_ctrl got=%h exp=%h", bus.out_ctrl, C_ADD_R0); end
      drive(1'b0, 32'h0, 32'h0);
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h407302B3, 32'h110);
      tick();
      total++; if (bus.out_ctrl !== C_SUB_R) begin bad++; $display("FAIL sub_ctrl got=%h exp=%h", bus.out_ctrl, C_SUB_R); end
      total++; if ({bus.out_rs1, bus.out_rs2, bus.out_rd} !== {5'd6, 5'd7, 5'd5}) begin
         bad++; $display("FAIL sub_regs got=%0d,%0d,%0d exp=6,7,5", bus.out_rs1, bus.out_rs2, bus.out_rd);
      end
      drive(1'b1, 32'hFFF00093, 32'h114);
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h114) begin
         bad++; $display("FAIL addi_valid got=%b pc=%h exp=1 pc=114", bus.out_valid, bus.out_pc);
      end
      total++; if (bus.out_ctrl !== C_ADD_I) begin bad++; $display("FAIL addi_ctrl got=%h exp=%h", bus.out_ctrl, C_ADD_I); end
      total++; if (bus.out_imm !== 32'hFFFFFFFF || bus.out_rd !== 5'd1 || bus.out_rs1 !== 5'd0) begin
         bad++; $display("FAIL addi_fields imm=%h rd=%0d rs1=%0d exp=ffffffff,1,0", bus.out_imm, bus.out_rd, bus.out_rs1);
      end
      drive(1'b0, 32'h0, 32'h0);
      tick();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h200);
      tick();
      drive(1'b1, 32'h0020C1B3, 32'h204);
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_ctrl !== C_ADD_R || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold[%0d] valid=%b pc=%h ctrl=%h in_ready=%b exp 1,200,%h,0",
                            i, bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready, C_ADD_R);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h204 || bus.out_ctrl !== C_XOR_R) begin
         bad++; $display("FAIL bp_next valid=%b pc=%h ctrl=%h exp 1,204,%h", bus.out_valid, bus.out_pc, bus.out_ctrl, C_XOR_R);
      end
      drive(1'b0, 32'h0, 32'h0);
      tick();
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h300);
      tick();
      drive(1'b1, 32'h000010B7, 32'h304);
      flush_i = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
      tick();
      flush_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
      total++; if (illegal_cnt !== 8'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", illegal_cnt); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_after got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h000010B7, 32'h400);
      tick();
      total++; if (bus.out_illegal !== 1'b1 || bus.out_ctrl !== C_NOP || bus.out_rd !== 5'd1) begin
         bad++; $display("FAIL lui_decode ill=%b ctrl=%h rd=%0d exp 1,%h,1", bus.out_illegal, bus.out_ctrl, bus.out_rd, C_NOP);
      end
      total++; if (illegal_cnt !== 8'd1) begin bad++; $display("FAIL lui_cnt got=%0d exp=1", illegal_cnt); end
      drive(1'b1, 32'h4020C1B3, 32'h404);
      tick();
      total++; if (bus.out_illegal !== 1'b1 || illegal_cnt !== 8'd2) begin
         bad++; $display("FAIL sub_f3_illegal ill=%b cnt=%0d exp 1,2", bus.out_illegal, illegal_cnt);
      end
      drive(1'b1, 32'h000010B7, 32'h408);
      for (int i = 0; i < 300; i++) tick();
      drive(1'b0, 32'h0, 32'h0);
      tick();
      total++; if (illegal_cnt !== 8'd255) begin bad++; $display("FAIL cnt_saturate got=%0d exp=255", illegal_cnt); end
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h500);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%b exp=1", bus.out_valid); end
      #3 rst = 1'b1;
      #1;
      total++; if (bus.out_valid !== 1'b0 || illegal_cnt !== 8'd0) begin
         bad++; $display("FAIL arst_immediate valid=%b cnt=%0d exp 0,0", bus.out_valid, illegal_cnt);
      end
      total++; if (bus.out_pc !== 32'h0 || bus.out_ctrl !== C_NOP) begin
         bad++; $display("FAIL arst_payload pc=%h ctrl=%h exp 0,%h", bus.out_pc, bus.out_ctrl, C_NOP);
      end
      tick();
      rst = 1'b0;
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_after got=%b exp=0", bus.out_valid); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_illegal();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
